// File: rtl/frame_rate_meter_pkg.sv
// fps_pkg: shared types and constants for the frame rate meter.
//   fps_state_t : measurement FSM state encoding
//   COUNT_W     : width of the reported frames-per-second value
//   COUNT_MAX   : saturation ceiling of the frame counter / report
//   sat_inc     : saturating increment used by the frame counter
package fps_pkg;

    typedef enum logic {ST_IDLE, ST_MEASURE} fps_state_t;

    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                   input logic inc);
        return (inc && (v != COUNT_MAX)) ? v + COUNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/frame_rate_meter_if.sv
// frame_rate_meter_if: control and result signals of the frame rate meter.
//   enable      : measure when high, idle and hold the last result when low
//   vsync_in    : camera vsync, asynchronous to clk
//   count       : frames in the last completed window, saturated at 255
//   count_valid : one-cycle pulse when count/overflow update
//   overflow    : last completed window saw more than 255 frames
// master = source of enable/vsync (capture side), slave = the meter.
interface frame_rate_meter_if;
    import fps_pkg::*;

    logic               enable;
    logic               vsync_in;
    logic [COUNT_W-1:0] count;
    logic               count_valid;
    logic               overflow;

    modport master (output enable, output vsync_in,
                    input  count, input count_valid, input overflow);
    modport slave  (input  enable, input vsync_in,
                    output count, output count_valid, output overflow);
endinterface

// File: rtl/frame_rate_meter_sync_rise_detect.sv
// sync_rise_detect: brings an asynchronous level into the clk domain and
// flags its rising edges.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   async_in : asynchronous input level
//   rise     : high for one cycle after a synchronized 0->1 transition
module sync_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);
    logic sync1_q, sync1_d;
    logic vs_s_q,  vs_s_d;
    logic vs_d_q,  vs_d_d;

    always_comb begin
        sync1_d = async_in;
        vs_s_d  = sync1_q;
        vs_d_d  = vs_s_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            vs_s_q  <= 1'b0;
            vs_d_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            vs_s_q  <= vs_s_d;
            vs_d_q  <= vs_d_d;
        end
    end

    assign rise = vs_s_q & ~vs_d_q;
endmodule

// File: rtl/frame_rate_meter.sv
// frame_rate_meter: counts camera vsync rising edges over a fixed window of
// WINDOW_CYCLES clocks and reports a saturating 8-bit frames-per-second value.
//   clk   : system clock
//   reset : asynchronous active-high reset, aborts any window in progress
//   bus   : frame_rate_meter_if.slave (enable, vsync_in -> count,
//           count_valid, overflow)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | counters cleared, last result held, waiting for enable
// ST_MEASURE | window running; leaving on enable low discards the window
module frame_rate_meter
    import fps_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100_000_000
) (
    input  logic                clk,
    input  logic                reset,
    frame_rate_meter_if.slave   bus
);
    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic rise;

    fps_state_t         state_q,       state_d;
    logic [WIN_W-1:0]   win_cnt_q,     win_cnt_d;
    logic [COUNT_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic               sat_flag_q,    sat_flag_d;
    logic [COUNT_W-1:0] count_q,       count_d;
    logic               count_valid_q, count_valid_d;
    logic               overflow_q,    overflow_d;

    // A rise arriving while the counter is already pinned at the ceiling
    // is a frame that cannot be represented.
    logic lost_frame;
    assign lost_frame = rise & (frame_cnt_q == COUNT_MAX);

    sync_rise_detect u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.vsync_in),
        .rise     (rise)
    );

    always_comb begin
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        sat_flag_d    = sat_flag_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                win_cnt_d   = '0;
                frame_cnt_d = '0;
                sat_flag_d  = 1'b0;
                if (bus.enable) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!bus.enable) begin
                    state_d     = ST_IDLE;
                    win_cnt_d   = '0;
                    frame_cnt_d = '0;
                    sat_flag_d  = 1'b0;
                end else if (win_cnt_q == WIN_LAST) begin
                    // The closing cycle's rise still belongs to this window.
                    count_d       = sat_inc(frame_cnt_q, rise);
                    overflow_d    = sat_flag_q | lost_frame;
                    count_valid_d = 1'b1;
                    win_cnt_d     = '0;
                    frame_cnt_d   = '0;
                    sat_flag_d    = 1'b0;
                end else begin
                    win_cnt_d   = win_cnt_q + WIN_W'(1);
                    frame_cnt_d = sat_inc(frame_cnt_q, rise);
                    sat_flag_d  = sat_flag_q | lost_frame;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            win_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            sat_flag_q    <= 1'b0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            sat_flag_q    <= sat_flag_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.count       = count_q;
    assign bus.count_valid = count_valid_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_frame_rate_meter.sv
// tb_frame_rate_meter: directed bench for frame_rate_meter with a 1000-cycle
// window. The stimulus thread pushes the expected report of each window
// (count, overflow, clock edge of the count_valid pulse) into a queue; a
// monitor pops and compares on every count_valid pulse.
module tb_frame_rate_meter;
    import fps_pkg::*;

    localparam int WIN = 1000;

    typedef struct {
        int cnt;
        int ovf;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    frame_rate_meter_if bus ();

    frame_rate_meter #(.WINDOW_CYCLES(WIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every count_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.count_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got count %0d at cycle %0d, expected no report",
                         bus.count, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("report_count", int'(bus.count), e.cnt);
                check("report_overflow", int'(bus.overflow), e.ovf);
                check("report_cycle", cyc, e.at);
            end
        end
    end

    function automatic void push(input int cnt, input int ovf, input int at);
        exp_t e;
        e.cnt = cnt;
        e.ovf = ovf;
        e.at  = at;
        sb.push_back(e);
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // n pulses, each hi cycles high then lo cycles low, starting now.
    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            bus.vsync_in = 1'b1;
            repeat (hi) @(negedge clk);
            bus.vsync_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    int c0, c1, r;

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_count", int'(bus.count), 0);
        check("reset_valid", int'(bus.count_valid), 0);
        check("reset_overflow", int'(bus.overflow), 0);
        reset = 1'b0;
        @(negedge clk);

        // 7 frames in the first window, report 1000 edges after enable.
        c0 = cyc;
        bus.enable = 1'b1;
        push(7, 0, c0 + WIN + 1);
        pulses(7, 3, 3);

        // Continuous 6-cycle period over two back-to-back windows.
        push(167, 0, c0 + 2*WIN + 1);
        push(166, 0, c0 + 3*WIN + 1);
        wait_until(c0 + WIN + 1);
        pulses(333, 3, 3);

        // 250 frames, then 300 frames (saturates with overflow).
        push(250, 0, c0 + 4*WIN + 1);
        wait_until(c0 + 3*WIN);
        pulses(250, 2, 2);
        push(255, 1, c0 + 5*WIN + 1);
        pulses(300, 2, 1);

        // Drop enable at win_cnt = 500 after 4 frames: no report, result held.
        wait_until(c0 + 5*WIN);
        pulses(4, 3, 3);
        wait_until(c0 + 5*WIN + 501);
        bus.enable = 1'b0;
        wait_until(c0 + 5*WIN + 600);
        check("hold_count", int'(bus.count), 255);
        check("hold_overflow", int'(bus.overflow), 1);
        pulses(2, 3, 3);

        // Re-enable: only the 3 frames after re-enable are reported.
        wait_until(c0 + 5*WIN + 620);
        c1 = cyc;
        bus.enable = 1'b1;
        push(3, 0, c1 + WIN + 1);
        wait_until(c1 + 10);
        pulses(3, 3, 3);

        // Rise coinciding with win_cnt = 999 counts in the closing window.
        push(3, 0, c1 + 2*WIN + 1);
        push(1, 0, c1 + 3*WIN + 1);
        wait_until(c1 + WIN + 100);
        pulses(2, 3, 3);
        wait_until(c1 + 2*WIN - 2);
        pulses(1, 3, 3);
        wait_until(c1 + 2*WIN + 100);
        pulses(1, 3, 3);

        // Reset mid-window after 5 frames clears outputs without a clock edge.
        wait_until(c1 + 3*WIN + 10);
        pulses(5, 3, 3);
        wait_until(c1 + 3*WIN + 50);
        check("pre_reset_count", int'(bus.count), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_count", int'(bus.count), 0);
        check("async_reset_valid", int'(bus.count_valid), 0);
        check("async_reset_overflow", int'(bus.overflow), 0);
        @(negedge clk);
        r = cyc;
        reset = 1'b0;
        push(2, 0, r + WIN + 1);
        wait_until(r + 20);
        pulses(2, 3, 3);
        wait_until(r + WIN + 5);
        bus.enable = 1'b0;
        wait_until(r + WIN + 20);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_rate_meter.md
# frame_rate_meter

Measures the camera frame rate for the 7-segment display. It counts rising edges of the camera vsync over a fixed one-second window and latches the result as an 8-bit, saturating frames-per-second value. That value drives the `count` input of the FND display controller directly. The block sits between the camera capture front-end and the display controller.

## Interface
- `WINDOW_CYCLES`, default 100_000_000: window length in `clk` cycles, which is 1 s at 100 MHz. Legal range is ≥ 4.
- `clk` input, 1 bit: system clock. Single clock domain.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `enable` input, 1 bit: synchronous. High means measure; low means idle and hold the last result.
- `vsync_in` input, 1 bit: camera vsync, asynchronous to `clk`. A rising edge marks one frame.
- `count` output, 8 bits: frames counted in the last completed window, saturated at 255. Feeds the display controller.
- `count_valid` output, 1 bit: one-cycle pulse when `count` updates.
- `overflow` output, 1 bit: high when the last completed window exceeded 255 frames. Updates together with `count`.

## Operation
**Input path**
- `vsync_in` passes through a 2-flop synchronizer into `vs_s`.
- A third flop `vs_d` delays `vs_s`; `rise = vs_s & ~vs_d`.
- `rise` is counted only in MEASURE.

**FSM states: IDLE, MEASURE**
- IDLE:
  - `win_cnt = 0`, `frame_cnt = 0`.
  - `count` and `overflow` hold; `count_valid = 0`.
  - Moves to MEASURE on a clock edge where `enable = 1`.
- MEASURE:
  - `win_cnt` increments every cycle, 0 … `WINDOW_CYCLES-1`.
  - `frame_cnt` increments on `rise`.
  - Moves to IDLE on a clock edge where `enable = 0`. The partial window is discarded: no `count_valid`, and `count`/`overflow` are unchanged.

**Window close** (MEASURE and `win_cnt == WINDOW_CYCLES-1`):
- `count` ← `min(frame_cnt + rise, 255)`.
- `overflow` ← `sat_flag | (rise & frame_cnt == 255)`.
- `count_valid` ← 1 for one cycle.
- `win_cnt` ← 0, `frame_cnt` ← 0, `sat_flag` ← 0. The next window starts with no gap.
- A `rise` in the closing cycle belongs to the closing window.

**Arithmetic**
- `frame_cnt` is 8 bits and saturates at 255; it never wraps.
- `sat_flag` is set on any `rise` while `frame_cnt == 255`.
- `win_cnt` width is `$clog2(WINDOW_CYCLES)`.

**Reset**
- Any cycle, including mid-window, aborts the measurement.
- All flops clear. State goes to IDLE.
- `count = 0`, `count_valid = 0`, `overflow = 0`, sync and delay flops = 0.

## Timing
- A vsync rise sampled at edge k is captured in sync flop 1 at k, appears on `vs_s` at k+1, and `rise` is high during cycle k+1…k+2. It is counted in `frame_cnt` at edge k+2.
- Minimum detectable vsync pulse width and low time: 2 `clk` periods each. Shorter pulses may be missed.
- With `enable` high at edge e0, MEASURE is entered at e0 and `win_cnt = 0` in the cycle after e0. `count`/`count_valid` become registered-valid at edge e0 + `WINDOW_CYCLES`, then every `WINDOW_CYCLES` edges after that.
- `count` is registered and stable between pulses. The display controller samples it asynchronously, so no handshake is needed.

## Structure
- Package `fps_pkg` holds:
  - `typedef enum logic {ST_IDLE, ST_MEASURE} fps_state_t`.
  - `localparam COUNT_W = 8`.
  - `localparam COUNT_MAX = 8'd255`.
- Sub-module `sync_rise_detect` (`clk`, `reset`, `async_in` → `rise`) contains the 2-flop synchronizer, the delay flop and the edge AND.
- The top level contains the FSM, `win_cnt`, `frame_cnt`, `sat_flag` and the output registers.

## Test plan
Benches use `WINDOW_CYCLES = 1000`, `clk` at 100 MHz, and vsync pulses 3 cycles high / 3 cycles low unless stated otherwise.
- Reset, then `enable = 1`, then 7 vsync pulses in the first window → `count_valid` pulses once, 1000 edges after `enable`; `count = 7`, `overflow = 0`.
- Continuous pulses at a 6-cycle period → `count = 166` or `167` every window, consecutive `count_valid` pulses exactly 1000 cycles apart, no gap windows.
- Pulses at a 4-cycle period (250 per window), then at a 3-cycle period with 2 high / 1 low … adjusted so 300 edges occur in the window → first window gives `count = 250`, `overflow = 0`; second gives `count = 255`, `overflow = 1`.
- `enable` dropped at `win_cnt = 500` after 4 pulses → no `count_valid` and `count` holds its prior value. Re-enable → the fresh window reports only frames seen after re-enable.
- A vsync rise timed so `rise` coincides with `win_cnt = 999` → it is counted in the closing window (N+1), and the next window starts at 0.
- `reset` asserted mid-window after 5 pulses → `count = 0`, `count_valid = 0`, `overflow = 0` immediately (asynchronously). After release with `enable` high, the first report comes 1000 edges later.
